// File: rtl/esteira_sequenciador_if.sv
// Conveyor sequencer bundle: operator/CQ inputs toward the sequencer, station flags and counters back to the VGA top.
// Plain level signals with no handshake; the sequencer samples inputs on every rising clock edge.
interface esteira_sequenciador_if;
  logic       start;
  logic       stop;
  logic       cq_ok;
  logic       repor_rolhas;
  logic [2:0] estado_atual;
  logic       motor;
  logic       Motor_Parado_Pos_Enchimento;
  logic       Motor_Parado_Pos_CQ;
  logic       Motor_Parado_Pos_Lacre;
  logic       val_enchimento;
  logic [3:0] rolhas;
  logic [7:0] garrafas_ok;
  logic [7:0] garrafas_descartadas;

  modport master (
    output start, stop, cq_ok, repor_rolhas,
    input  estado_atual, motor, Motor_Parado_Pos_Enchimento, Motor_Parado_Pos_CQ,
    input  Motor_Parado_Pos_Lacre, val_enchimento, rolhas, garrafas_ok, garrafas_descartadas
  );

  modport slave (
    input  start, stop, cq_ok, repor_rolhas,
    output estado_atual, motor, Motor_Parado_Pos_Enchimento, Motor_Parado_Pos_CQ,
    output Motor_Parado_Pos_Lacre, val_enchimento, rolhas, garrafas_ok, garrafas_descartadas
  );
endinterface

// File: rtl/esteira_sequenciador.sv
// Wine-bottle conveyor sequencer: fill -> cork -> CQ -> seal, one bottle at a time, timed in prescaled ticks.
// All outputs registered, updated on the same edge as state/phase; no backpressure, a stop request lets the bottle finish.
module esteira_sequenciador #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int T_MOVE      = 2,
  parameter int T_FILL      = 3,
  parameter int T_VEDA      = 1,
  parameter int ROLHAS_INIT = 5
) (
  input  logic                   MAX10_CLK1_50,
  input  logic                   reset,
  esteira_sequenciador_if.slave  bus
);

  typedef enum logic [2:0] {
    PARADO        = 3'b000,
    AG_ENCHIMENTO = 3'b001,
    AG_VEDACAO    = 3'b010,
    FALTA_ROLHA   = 3'b011,
    AG_CQ         = 3'b100,
    AG_LACRE      = 3'b101
  } estado_t;

  typedef enum logic {
    MOVE = 1'b0,
    STOP = 1'b1
  } fase_t;

  localparam int              PW           = $clog2(TICK_DIV + 1);
  localparam int              TW           = 8;
  localparam logic [PW-1:0]   PRESC_MAX    = PW'(TICK_DIV - 1);
  localparam logic [3:0]      ROLHAS_CHEIO = 4'(ROLHAS_INIT);

  estado_t       estado;
  fase_t         fase;
  logic [PW-1:0] presc;
  logic [TW-1:0] ticks;
  logic          stop_req;
  logic          motor_q;
  logic          pos_ench_q;
  logic          pos_cq_q;
  logic          pos_lacre_q;
  logic          val_q;
  logic [3:0]    rolhas_q;
  logic [7:0]    ok_q;
  logic [7:0]    desc_q;

  logic tick;
  logic fim_move;
  logic fim_fill;
  logic fim_veda;
  logic fim_cq;

  assign tick     = (presc == PRESC_MAX);
  assign fim_move = tick && (ticks == TW'(T_MOVE - 1));
  assign fim_fill = tick && (ticks == TW'(T_FILL - 1));
  assign fim_veda = tick && (ticks == TW'(T_VEDA - 1));
  assign fim_cq   = tick && (ticks == '0);

  // Every transition below clears presc/ticks so the new phase starts a fresh count.
  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      estado      <= PARADO;
      fase        <= MOVE;
      presc       <= '0;
      ticks       <= '0;
      stop_req    <= 1'b0;
      motor_q     <= 1'b0;
      pos_ench_q  <= 1'b0;
      pos_cq_q    <= 1'b0;
      pos_lacre_q <= 1'b0;
      val_q       <= 1'b0;
      rolhas_q    <= ROLHAS_CHEIO;
      ok_q        <= '0;
      desc_q      <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        ticks <= ticks + 1'b1;
      end
      if (bus.stop && (estado != PARADO)) begin
        stop_req <= 1'b1;
      end
      if (bus.repor_rolhas) begin
        rolhas_q <= ROLHAS_CHEIO;
      end

      case (estado)
        PARADO: begin
          stop_req <= 1'b0;
          if (bus.start && !bus.stop) begin
            estado  <= AG_ENCHIMENTO;
            fase    <= MOVE;
            motor_q <= 1'b1;
            presc   <= '0;
            ticks   <= '0;
          end
        end

        AG_ENCHIMENTO: begin
          if (fase == MOVE) begin
            if (fim_move) begin
              fase       <= STOP;
              motor_q    <= 1'b0;
              pos_ench_q <= 1'b1;
              val_q      <= 1'b1;
              presc      <= '0;
              ticks      <= '0;
            end
          end else if (fim_fill) begin
            estado     <= AG_VEDACAO;
            fase       <= STOP;
            pos_ench_q <= 1'b0;
            val_q      <= 1'b0;
            presc      <= '0;
            ticks      <= '0;
          end
        end

        AG_VEDACAO: begin
          // An empty magazine refilled in this very cycle is not a shortage.
          if ((rolhas_q == '0) && !bus.repor_rolhas) begin
            estado <= FALTA_ROLHA;
            presc  <= '0;
            ticks  <= '0;
          end else if (fim_veda) begin
            if (!bus.repor_rolhas) begin
              rolhas_q <= rolhas_q - 1'b1;
            end
            estado  <= AG_CQ;
            fase    <= MOVE;
            motor_q <= 1'b1;
            presc   <= '0;
            ticks   <= '0;
          end
        end

        FALTA_ROLHA: begin
          if (bus.repor_rolhas) begin
            estado <= AG_VEDACAO;
            fase   <= STOP;
            presc  <= '0;
            ticks  <= '0;
          end
        end

        AG_CQ: begin
          if (fase == MOVE) begin
            if (fim_move) begin
              fase     <= STOP;
              motor_q  <= 1'b0;
              pos_cq_q <= 1'b1;
              presc    <= '0;
              ticks    <= '0;
            end
          end else if (fim_cq) begin
            pos_cq_q <= 1'b0;
            presc    <= '0;
            ticks    <= '0;
            if (bus.cq_ok) begin
              estado  <= AG_LACRE;
              fase    <= MOVE;
              motor_q <= 1'b1;
            end else begin
              if (desc_q != 8'hFF) begin
                desc_q <= desc_q + 1'b1;
              end
              if (stop_req) begin
                estado   <= PARADO;
                fase     <= MOVE;
                stop_req <= 1'b0;
              end else begin
                estado  <= AG_ENCHIMENTO;
                fase    <= MOVE;
                motor_q <= 1'b1;
              end
            end
          end
        end

        AG_LACRE: begin
          if (fase == MOVE) begin
            if (fim_move) begin
              fase        <= STOP;
              motor_q     <= 1'b0;
              pos_lacre_q <= 1'b1;
              presc       <= '0;
              ticks       <= '0;
            end
          end else if (fim_veda) begin
            pos_lacre_q <= 1'b0;
            presc       <= '0;
            ticks       <= '0;
            if (ok_q != 8'hFF) begin
              ok_q <= ok_q + 1'b1;
            end
            if (stop_req) begin
              estado   <= PARADO;
              fase     <= MOVE;
              stop_req <= 1'b0;
            end else begin
              estado  <= AG_ENCHIMENTO;
              fase    <= MOVE;
              motor_q <= 1'b1;
            end
          end
        end

        default: begin
          estado      <= PARADO;
          fase        <= MOVE;
          motor_q     <= 1'b0;
          pos_ench_q  <= 1'b0;
          pos_cq_q    <= 1'b0;
          pos_lacre_q <= 1'b0;
          val_q       <= 1'b0;
          presc       <= '0;
          ticks       <= '0;
        end
      endcase
    end
  end

  assign bus.estado_atual                = estado;
  assign bus.motor                       = motor_q;
  assign bus.Motor_Parado_Pos_Enchimento = pos_ench_q;
  assign bus.Motor_Parado_Pos_CQ         = pos_cq_q;
  assign bus.Motor_Parado_Pos_Lacre      = pos_lacre_q;
  assign bus.val_enchimento              = val_q;
  assign bus.rolhas                      = rolhas_q;
  assign bus.garrafas_ok                 = ok_q;
  assign bus.garrafas_descartadas        = desc_q;

endmodule

// File: tb/tb_esteira_sequenciador.sv
// Bench for esteira_sequenciador: per-cycle expected timeline built from the bottle rules, plus reset scenarios.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_esteira_sequenciador;

  localparam int TD     = 4;
  localparam int TMV    = 2;
  localparam int TFL    = 3;
  localparam int TVD    = 1;
  localparam int R_INIT = 2;

  // flags order: motor, Pos_Enchimento, Pos_CQ, Pos_Lacre, val_enchimento
  localparam logic [4:0] F_IDLE = 5'b00000;
  localparam logic [4:0] F_MOVE = 5'b10000;
  localparam logic [4:0] F_FILL = 5'b01001;
  localparam logic [4:0] F_CQ   = 5'b00100;
  localparam logic [4:0] F_LAC  = 5'b00010;

  // actions applied right after a cycle is sampled: start, stop, repor pulses; cq_ok level set
  localparam logic [4:0] A_NONE  = 5'b00000;
  localparam logic [4:0] A_START = 5'b10000;
  localparam logic [4:0] A_STOP  = 5'b01000;
  localparam logic [4:0] A_REPOR = 5'b00100;
  localparam logic [4:0] A_CQ0   = 5'b00010;
  localparam logic [4:0] A_CQ1   = 5'b00011;

  typedef struct packed {
    logic [2:0] est;
    logic [4:0] flg;
    logic [3:0] rol;
    logic [7:0] ok;
    logic [7:0] dsc;
  } snap_t;

  typedef struct packed {
    snap_t      s;
    logic [4:0] a;
  } ent_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   m_rol;
  int   m_ok;
  int   m_dsc;
  ent_t exp_q[$];

  esteira_sequenciador_if bus ();

  esteira_sequenciador #(
    .TICK_DIV   (TD),
    .T_MOVE     (TMV),
    .T_FILL     (TFL),
    .T_VEDA     (TVD),
    .ROLHAS_INIT(R_INIT)
  ) dut (
    .MAX10_CLK1_50(clk),
    .reset        (rst),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic snap_t observe();
    snap_t s;
    s.est = bus.estado_atual;
    s.flg = {bus.motor, bus.Motor_Parado_Pos_Enchimento, bus.Motor_Parado_Pos_CQ,
             bus.Motor_Parado_Pos_Lacre, bus.val_enchimento};
    s.rol = bus.rolhas;
    s.ok  = bus.garrafas_ok;
    s.dsc = bus.garrafas_descartadas;
    return s;
  endfunction

  function automatic void push(input logic [2:0] est, input logic [4:0] flg, input int n,
                               input logic [4:0] a_first, input logic [4:0] a_last);
    ent_t e;
    for (int i = 0; i < n; i++) begin
      e.s.est = est;
      e.s.flg = flg;
      e.s.rol = 4'(m_rol);
      e.s.ok  = 8'(m_ok);
      e.s.dsc = 8'(m_dsc);
      e.a     = A_NONE;
      if (i == 0)     e.a = e.a | a_first;
      if (i == n - 1) e.a = e.a | a_last;
      exp_q.push_back(e);
    end
  endfunction

  // One bottle from entering the fill move until it leaves seal/CQ.
  function automatic void model_bottle(input bit ok, input bit stp, input int delay, input bit repor_veda);
    push(3'd1, F_MOVE, TD * TMV, ok ? A_CQ1 : A_CQ0, stp ? A_STOP : A_NONE);
    push(3'd1, F_FILL, TD * TFL, A_NONE, A_NONE);
    if (m_rol == 0) begin
      push(3'd2, F_IDLE, 1, A_NONE, A_NONE);
      push(3'd3, F_IDLE, delay, A_NONE, A_REPOR);
      m_rol = R_INIT;
    end
    push(3'd2, F_IDLE, TD * TVD, A_NONE, repor_veda ? A_REPOR : A_NONE);
    m_rol = repor_veda ? R_INIT : m_rol - 1;
    push(3'd4, F_MOVE, TD * TMV, A_NONE, A_NONE);
    push(3'd4, F_CQ, TD, A_NONE, A_NONE);
    if (ok) begin
      push(3'd5, F_MOVE, TD * TMV, A_NONE, A_NONE);
      push(3'd5, F_LAC, TD * TVD, A_NONE, A_NONE);
      m_ok = (m_ok == 255) ? 255 : m_ok + 1;
    end else begin
      m_dsc = (m_dsc == 255) ? 255 : m_dsc + 1;
    end
  endfunction

  task automatic test_reset();
    snap_t g;
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.cq_ok = 1'b0; bus.repor_rolhas = 1'b0;
    repeat (3) @(negedge clk);
    g = observe();
    checks++; if (g.est !== 3'd0) begin errors++; $display("FAIL reset_estado got %0d want 0", g.est); end
    checks++; if (g.flg !== 5'b0) begin errors++; $display("FAIL reset_flags got %b want 00000", g.flg); end
    checks++; if (g.rol !== 4'(R_INIT)) begin errors++; $display("FAIL reset_rolhas got %0d want %0d", g.rol, R_INIT); end
    checks++; if (g.ok !== 8'd0) begin errors++; $display("FAIL reset_ok got %0d want 0", g.ok); end
    checks++; if (g.dsc !== 8'd0) begin errors++; $display("FAIL reset_desc got %0d want 0", g.dsc); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.estado_atual !== 3'd0) begin errors++; $display("FAIL idle_after_reset got %0d want 0", bus.estado_atual); end
  endtask

  task automatic test_park_start_stop();
    bus.start = 1'b1; bus.stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.estado_atual !== 3'd0 || bus.motor !== 1'b0) begin
        errors++; $display("FAIL park_start_stop[%0d] got est=%0d motor=%b want est=0 motor=0", i, bus.estado_atual, bus.motor);
      end
    end
    bus.start = 1'b0; bus.stop = 1'b0;
    @(negedge clk);
    checks++; if (bus.estado_atual !== 3'd0) begin errors++; $display("FAIL park_release got %0d want 0", bus.estado_atual); end
  endtask

  task automatic test_bottle_stream();
    ent_t  e;
    snap_t g;
    int    idx;
    bit    ok, stp;
    m_rol = R_INIT; m_ok = 0; m_dsc = 0;
    exp_q.delete();
    push(3'd0, F_IDLE, 2, A_NONE, A_START);
    model_bottle(1'b1, 1'b0, 1, 1'b0);     // good bottle, 2 -> 1 cork
    model_bottle(1'b0, 1'b0, 1, 1'b0);     // reject, magazine now empty
    model_bottle(1'b1, 1'b1, 3, 1'b0);     // cork shortage, refill, stop during fill
    push(3'd0, F_IDLE, 3, A_NONE, A_START);
    model_bottle(1'b1, 1'b0, 1, 1'b1);     // refill on the decrement edge wins
    for (int b = 0; b < 12; b++) begin
      ok  = bit'($urandom_range(0, 1));
      stp = (b == 11) || ($urandom_range(0, 3) == 0);
      model_bottle(ok, stp, int'($urandom_range(1, 5)), $urandom_range(0, 4) == 0);
      if (stp && b != 11) push(3'd0, F_IDLE, int'($urandom_range(1, 3)), A_NONE, A_START);
    end
    push(3'd0, F_IDLE, 2, A_NONE, A_NONE);
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      g = observe();
      checks++;
      if (g !== e.s) begin
        errors++;
        $display("FAIL stream[%0d] got est=%0d flg=%b rol=%0d ok=%0d dsc=%0d want est=%0d flg=%b rol=%0d ok=%0d dsc=%0d",
                 idx, g.est, g.flg, g.rol, g.ok, g.dsc, e.s.est, e.s.flg, e.s.rol, e.s.ok, e.s.dsc);
      end
      bus.start = e.a[4];
      bus.stop = e.a[3];
      bus.repor_rolhas = e.a[2];
      if (e.a[1]) bus.cq_ok = e.a[0];
      idx++;
    end
    bus.start = 1'b0; bus.stop = 1'b0; bus.repor_rolhas = 1'b0;
  endtask

  task automatic test_async_reset();
    bit    found;
    snap_t g;
    @(negedge clk); bus.repor_rolhas = 1'b1;
    @(negedge clk); bus.repor_rolhas = 1'b0;
    checks++; if (bus.rolhas !== 4'(R_INIT)) begin errors++; $display("FAIL refill_in_parado got %0d want %0d", bus.rolhas, R_INIT); end
    bus.cq_ok = 1'b1;
    bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (bus.estado_atual == 3'd4 && bus.motor == 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL reach_cq_move got est=%0d want est=4 with motor=1 within 200 cycles", bus.estado_atual);
    end else begin
      #2 rst = 1'b1;
      #1 g = observe();
      checks++; if (g.est !== 3'd0) begin errors++; $display("FAIL async_estado got %0d want 0", g.est); end
      checks++; if (g.flg !== 5'b0) begin errors++; $display("FAIL async_flags got %b want 00000", g.flg); end
      checks++; if (g.rol !== 4'(R_INIT)) begin errors++; $display("FAIL async_rolhas got %0d want %0d", g.rol, R_INIT); end
      checks++; if (g.ok !== 8'd0 || g.dsc !== 8'd0) begin errors++; $display("FAIL async_counters got ok=%0d dsc=%0d want 0 0", g.ok, g.dsc); end
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      checks++; if (bus.estado_atual !== 3'd0) begin errors++; $display("FAIL post_async_idle got %0d want 0", bus.estado_atual); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    test_reset();
    test_park_start_stop();
    test_bottle_stream();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
